// File: rtl/copperv_bus_pkg.sv
// Shared definitions for the copperv valid/ready bus responders: read FSM states,
// stall LFSR constants and the default bus width.
package copperv_bus_pkg;

  localparam int unsigned BusWidth = 32;

  // Fibonacci taps 8,6,5,4 map to register bits 7,5,4,3.
  localparam logic [7:0] LfsrSeed = 8'hA5;
  localparam logic [7:0] LfsrTaps = 8'hB8;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rstate_e;

  function automatic logic [7:0] lfsr_next(logic [7:0] cur);
    return {cur[6:0], ^(cur & LfsrTaps)};
  endfunction

endpackage

// File: rtl/copperv_stall_lfsr.sv
// Pseudo-random stall source; only instantiated when COPPERV_RESP_STALL_EN is defined.
module copperv_stall_lfsr
  import copperv_bus_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output logic stall
);

  logic [7:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign stall = lfsr_q[0];

endmodule

// File: rtl/copperv_mem_responder.sv
// Memory-side responder for one copperv bus port, backed by a word array.
// Define COPPERV_RESP_STALL_EN to inject pseudo-random ready stalls.
module copperv_mem_responder
  import copperv_bus_pkg::*;
#(
  parameter int bus_width    = BusWidth,
  parameter int depth_log2   = 10,
  parameter int read_latency = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 raddr_valid,
  output logic                 raddr_ready,
  input  logic [bus_width-1:0] raddr,
  output logic                 rdata_valid,
  input  logic                 rdata_ready,
  output logic [bus_width-1:0] rdata,
  input  logic                 waddr_valid,
  output logic                 waddr_ready,
  input  logic [bus_width-1:0] waddr,
  input  logic                 wdata_valid,
  output logic                 wdata_ready,
  input  logic [bus_width-1:0] wdata
);

  localparam int Words = 1 << depth_log2;

  logic [bus_width-1:0] mem [Words];

  logic stall;

`ifdef COPPERV_RESP_STALL_EN
  copperv_stall_lfsr u_stall_lfsr (
    .clk  (clk),
    .rst  (rst),
    .stall(stall)
  );
`else
  assign stall = 1'b0;
`endif

  // Byte addresses: low two bits and bits above the array size are dropped.
  logic [depth_log2-1:0] raddr_idx, waddr_idx;
  assign raddr_idx = raddr[depth_log2+1:2];
  assign waddr_idx = waddr[depth_log2+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{raddr[1:0], raddr[bus_width-1:depth_log2+2],
                              waddr[1:0], waddr[bus_width-1:depth_log2+2]};

  // Read path
  rstate_e               state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [depth_log2-1:0] ridx_q, ridx_d, rd_idx;
  logic                  rvalid_q;
  logic [bus_width-1:0]  rdata_q;
  logic                  load_rdata, clear_rvalid;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ridx_d       = ridx_q;
    rd_idx       = ridx_q;
    load_rdata   = 1'b0;
    clear_rvalid = 1'b0;
    raddr_ready  = 1'b0;
    case (state_q)
      R_IDLE: begin
        raddr_ready = rst && !stall;
        if (raddr_valid && raddr_ready) begin
          ridx_d = raddr_idx;
          cnt_d  = 4'(read_latency - 1);
          if (read_latency == 1) begin
            state_d    = R_RESP;
            load_rdata = 1'b1;
            rd_idx     = raddr_idx;
          end else begin
            state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = R_RESP;
          load_rdata = 1'b1;
        end
      end
      R_RESP: begin
        if (rdata_ready) begin
          state_d      = R_IDLE;
          clear_rvalid = 1'b1;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  // The array is sampled with the old contents when a write commits on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= R_IDLE;
      cnt_q    <= 4'd0;
      ridx_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ridx_q  <= ridx_d;
      if (load_rdata) begin
        rdata_q  <= mem[rd_idx];
        rvalid_q <= 1'b1;
      end else if (clear_rvalid) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign rdata_valid = rvalid_q;
  assign rdata       = rdata_q;

  // Write path: each channel holds one value until both halves are present.
  logic                  waddr_full_q, wdata_full_q;
  logic [depth_log2-1:0] widx_q;
  logic [bus_width-1:0]  wdata_q;
  logic                  commit;

  assign waddr_ready = rst && !waddr_full_q && !stall;
  assign wdata_ready = rst && !wdata_full_q && !stall;
  assign commit      = rst && waddr_full_q && wdata_full_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      waddr_full_q <= 1'b0;
      wdata_full_q <= 1'b0;
      widx_q       <= '0;
      wdata_q      <= '0;
    end else if (commit) begin
      waddr_full_q <= 1'b0;
      wdata_full_q <= 1'b0;
    end else begin
      if (waddr_valid && waddr_ready) begin
        waddr_full_q <= 1'b1;
        widx_q       <= waddr_idx;
      end
      if (wdata_valid && wdata_ready) begin
        wdata_full_q <= 1'b1;
        wdata_q      <= wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      mem[widx_q] <= wdata_q;
    end
  end

endmodule
